ahb_block_master: RTL and testbench
===================================

AHB_BLOCK_MASTER -- requirements
Module: ahb_block_master

Interface
REQ-001 SHALL have parameter DATA_ADDR, default 32'h0000_0010, meaning the byte address of beat 0 of every burst.
REQ-002 SHALL have parameter HPROT_VAL, default 4'b0011, meaning the constant value driven on HPROT.
REQ-003 SHALL have ports:
- HCLK  in  1  clock; all state updates on the rising edge.
- HRESET  in  1  reset; synchronous, active-high.
- start_wr  in  1  request to write wr_block.
- start_rd  in  1  request to read a block.
- wr_block  in  128  block to write; sampled on the accepted start.
- HREADY  in  1  slave ready.
- HRESP  in  2  slave response; 2'b00 OKAY, 2'b01 ERROR.
- HRDATA  in  32  read data.
- HADDR  out  32  address.
- HTRANS  out  2  transfer type.
- HWRITE  out  1  write strobe.
- HSIZE  out  3  transfer size.
- HBURST  out  3  burst type.
- HPROT  out  4  protection; equals HPROT_VAL.
- HWDATA  out  32  write data.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on an ERROR abort.
- rd_block  out  128  assembled read block; holds until the next read completes.

Function
REQ-004 SHALL act as an AHB-Lite initiator that moves one 128-bit block as 4 word beats to the addresses DATA_ADDR+0, +4, +8 and +12.
REQ-005 SHALL map beat 0 to bits [127:96] and beat 3 to bits [31:0], for both writes and reads.
REQ-006 SHALL drive HSIZE=3'b010 whenever HTRANS is not IDLE.
REQ-007 SHALL drive HTRANS=2'b00 (IDLE), HADDR=0, HWRITE=0 and HWDATA=0 whenever no address or data phase is pending.
REQ-008 SHALL implement the FSM states IDLE, ADDR0, BURST, LAST, DONE and ERR.
REQ-009 SHALL make the IDLE transitions: start_wr -> ADDR0 (write); otherwise start_rd -> ADDR0 (read). When both are high in the same cycle, the write SHALL win and the read SHALL be dropped.
REQ-010 SHALL ignore start_wr and start_rd in every state other than IDLE.
REQ-011 SHALL, in ADDR0, drive beat-0 address with HTRANS=NONSEQ; on HREADY the FSM SHALL go to BURST.
REQ-012 SHALL, in BURST, pipeline the bus: the address phase of beat n+1 overlaps the data phase of beat n. Beats 1-3 SHALL use HTRANS=SEQ. A 2-bit beat counter SHALL advance only on HREADY=1.
REQ-013 SHALL drive HWDATA with the word of the beat currently in its data phase.
REQ-014 SHALL capture HRDATA for a read beat only on a cycle where HREADY=1 and HRESP=OKAY.
REQ-015 SHALL, in LAST, drive HTRANS=IDLE while beat 3's data phase completes; on HREADY the FSM SHALL go to DONE.
REQ-016 SHALL, in DONE, pulse done for 1 cycle, update rd_block (reads only), then return to IDLE.
REQ-017 SHALL hold HADDR, HTRANS, HWRITE and HWDATA stable while HREADY=0 (wait states), with no limit on wait-state count.
REQ-018 SHALL respond to HRESP=ERROR with HREADY=0 (first cycle of the 2-cycle response) by driving HTRANS=IDLE on the next cycle, cancelling the remaining beats and entering ERR.
REQ-019 SHALL, in ERR, pulse error for 1 cycle, leave rd_block unchanged, then return to IDLE.
REQ-020 SHALL assert busy in ADDR0, BURST and LAST only.
REQ-021 SHALL meet zero-wait latency: start sampled in cycle 0 -> NONSEQ in cycle 1 -> HTRANS=IDLE in cycle 5 -> done in cycle 6.

Reset
REQ-022 SHALL, on HRESET=1 at a clock edge, go to IDLE, clear the beat counter and clear all outputs to 0 (HPROT excepted, which stays HPROT_VAL), including rd_block.
REQ-023 SHALL, on reset mid-burst, abort the burst with no done or error pulse; HTRANS SHALL be IDLE on the cycle after the reset edge.

Configuration
REQ-024 SHALL, when macro AHB_BLOCK_MASTER_BURST_EN is defined, use HBURST=3'b011 (INCR4) with beats 1-3 as SEQ.
REQ-025 SHALL, when AHB_BLOCK_MASTER_BURST_EN is undefined, use HBURST=3'b000 (SINGLE) with every beat NONSEQ. Pipelining, addresses and latency SHALL be unchanged.

Verification
REQ-026 SHALL cover a zero-wait write: wr_block=128'h00112233_44556677_8899AABB_CCDDEEFF with start_wr -> HWDATA 00112233, 44556677, 8899AABB, CCDDEEFF at HADDR 0x10, 0x14, 0x18, 0x1C; done in cycle 6.
REQ-027 SHALL cover a read with 2 wait states on beat 2: HRDATA words A0000000, B1111111, C2222222, D3333333 -> rd_block=128'hA0000000_B1111111_C2222222_D3333333; address and data held during the stalls; done in cycle 8.
REQ-028 SHALL cover simultaneous start_wr=1 and start_rd=1 -> a single write burst (HWRITE=1) and no later read.
REQ-029 SHALL cover ERROR on beat 1 -> HTRANS=IDLE on the following cycle, one error pulse, no done, rd_block unchanged.
REQ-030 SHALL cover HRESET asserted during beat 2 -> next cycle all outputs 0 and FSM in IDLE; a new start_wr then completes normally.
REQ-031 SHALL cover both macro builds: HBURST=3'b011 with SEQ beats when defined, and HBURST=3'b000 with all NONSEQ beats when undefined.

Source files
------------

// File: rtl/ahb_block_master.sv
// AHB-Lite initiator moving one 128-bit block as four pipelined word beats.
// Define AHB_BLOCK_MASTER_BURST_EN for INCR4/SEQ beats; default is SINGLE/NONSEQ beats.
module ahb_block_master #(
    parameter logic [31:0] DATA_ADDR = 32'h0000_0010,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic         HCLK,
    input  logic         HRESET,
    input  logic         start_wr,
    input  logic         start_rd,
    input  logic [127:0] wr_block,
    input  logic         HREADY,
    input  logic [1:0]   HRESP,
    input  logic [31:0]  HRDATA,
    output logic [31:0]  HADDR,
    output logic [1:0]   HTRANS,
    output logic         HWRITE,
    output logic [2:0]   HSIZE,
    output logic [2:0]   HBURST,
    output logic [3:0]   HPROT,
    output logic [31:0]  HWDATA,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [127:0] rd_block
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR0 = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_LAST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] R_OKAY   = 2'b00;
    localparam logic [1:0] R_ERROR  = 2'b01;

`ifdef AHB_BLOCK_MASTER_BURST_EN
    localparam logic [1:0] T_BEAT     = 2'b11;
    localparam logic [2:0] BURST_TYPE = 3'b011;
`else
    localparam logic [1:0] T_BEAT     = 2'b10;
    localparam logic [2:0] BURST_TYPE = 3'b000;
`endif

    logic [2:0]   state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         wr_q, wr_d;
    logic [127:0] wdata_q, wdata_d;
    logic [127:0] rbuf_q, rbuf_d;
    logic [127:0] rd_block_q, rd_block_d;
    logic [1:0]   data_beat;
    logic         err_first;

    // cnt_q names the beat in its address phase; in LAST it stays at 3 for the final data phase.
    assign data_beat = (state_q == S_LAST) ? cnt_q : cnt_q - 2'd1;
    assign err_first = (HRESP == R_ERROR) && !HREADY;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        rd_block_d = rd_block_q;
        case (state_q)
            S_IDLE: begin
                if (start_wr) begin
                    state_d = S_ADDR0;
                    wr_d    = 1'b1;
                    wdata_d = wr_block;
                    cnt_d   = 2'd0;
                end else if (start_rd) begin
                    state_d = S_ADDR0;
                    wr_d    = 1'b0;
                    cnt_d   = 2'd0;
                end
            end
            S_ADDR0: begin
                if (HREADY) begin
                    state_d = S_BURST;
                    cnt_d   = 2'd1;
                end
            end
            S_BURST: begin
                if (err_first) begin
                    state_d = S_ERR;
                end else if (HREADY) begin
                    if (!wr_q && HRESP == R_OKAY)
                        rbuf_d[{~data_beat, 5'b00000} +: 32] = HRDATA;
                    if (cnt_q == 2'd3)
                        state_d = S_LAST;
                    else
                        cnt_d = cnt_q + 2'd1;
                end
            end
            S_LAST: begin
                if (err_first) begin
                    state_d = S_ERR;
                end else if (HREADY) begin
                    state_d = S_DONE;
                    if (!wr_q && HRESP == R_OKAY) begin
                        rbuf_d[{~data_beat, 5'b00000} +: 32] = HRDATA;
                        rd_block_d = rbuf_d;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            rd_block_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            rd_block_q <= rd_block_d;
        end
    end

    // Bus outputs decode from registered state only, so they hold through wait states.
    always_comb begin
        HTRANS = T_IDLE;
        HADDR  = '0;
        HWRITE = 1'b0;
        HWDATA = '0;
        case (state_q)
            S_ADDR0: begin
                HTRANS = T_NONSEQ;
                HADDR  = DATA_ADDR;
                HWRITE = wr_q;
            end
            S_BURST: begin
                HTRANS = T_BEAT;
                HADDR  = DATA_ADDR + {28'd0, cnt_q, 2'b00};
                HWRITE = wr_q;
                HWDATA = wr_q ? wdata_q[{~data_beat, 5'b00000} +: 32] : '0;
            end
            S_LAST: begin
                HWRITE = wr_q;
                HWDATA = wr_q ? wdata_q[{~data_beat, 5'b00000} +: 32] : '0;
            end
            default: ;
        endcase
        HSIZE  = (HTRANS != T_IDLE) ? 3'b010 : 3'b000;
        HBURST = (HTRANS != T_IDLE) ? BURST_TYPE : 3'b000;
    end

    assign HPROT    = HPROT_VAL;
    assign busy     = (state_q == S_ADDR0) || (state_q == S_BURST) || (state_q == S_LAST);
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERR);
    assign rd_block = rd_block_q;

endmodule

// File: tb/tb_ahb_block_master.sv
// Directed bench for ahb_block_master; honours AHB_BLOCK_MASTER_BURST_EN for HTRANS/HBURST expectations.
module tb_ahb_block_master;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic         start_wr, start_rd;
    logic [127:0] wr_block;
    logic         HREADY;
    logic [1:0]   HRESP;
    logic [31:0]  HRDATA;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [2:0]   HSIZE, HBURST;
    logic [3:0]   HPROT;
    logic [31:0]  HWDATA;
    logic         busy, done, error;
    logic [127:0] rd_block;

    int tests = 0;
    int failed = 0;

`ifdef AHB_BLOCK_MASTER_BURST_EN
    localparam logic [1:0] TB_EXP = 2'b11;
    localparam logic [2:0] HB_EXP = 3'b011;
`else
    localparam logic [1:0] TB_EXP = 2'b10;
    localparam logic [2:0] HB_EXP = 3'b000;
`endif
    localparam logic [127:0] RD_EXP = 128'hA0000000_B1111111_C2222222_D3333333;

    ahb_block_master #(.DATA_ADDR(32'h0000_0010), .HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start_wr(start_wr), .start_rd(start_rd),
        .wr_block(wr_block), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .busy(busy),
        .done(done), .error(error), .rd_block(rd_block)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1; start_wr = 0; start_rd = 0; wr_block = '0;
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
        tick(); tick();
        tests++;
        if ({HTRANS, HADDR, HWRITE, HWDATA, HSIZE, HBURST, busy, done, error} !== '0) begin
            failed++;
            $display("FAIL reset_bus: got trans=%h addr=%h wr=%b wdata=%h size=%h burst=%h busy=%b done=%b err=%b, want all 0",
                     HTRANS, HADDR, HWRITE, HWDATA, HSIZE, HBURST, busy, done, error);
        end
        tests++;
        if (rd_block !== '0) begin failed++; $display("FAIL reset_rd_block: got %h want 0", rd_block); end
        tests++;
        if (HPROT !== 4'b0011) begin failed++; $display("FAIL reset_hprot: got %h want 3", HPROT); end
        HRESET = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait_write();
        logic [1:0]  et [1:7];
        logic [31:0] ea [1:7];
        logic [31:0] ed [1:7];
        logic        eb [1:7];
        logic        edn [1:7];
        et  = '{2'b10, TB_EXP, TB_EXP, TB_EXP, 2'b00, 2'b00, 2'b00};
        ea  = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h0, 32'h0, 32'h0};
        ed  = '{32'h0, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 32'h0, 32'h0};
        eb  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        edn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        HREADY = 1'b1; HRESP = 2'b00;
        wr_block = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        start_wr = 1'b1;
        tick();
        start_wr = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tests++;
            if (HTRANS !== et[k]) begin failed++; $display("FAIL wr_htrans c%0d: got %h want %h", k, HTRANS, et[k]); end
            tests++;
            if (HADDR !== ea[k]) begin failed++; $display("FAIL wr_haddr c%0d: got %h want %h", k, HADDR, ea[k]); end
            tests++;
            if (HWDATA !== ed[k]) begin failed++; $display("FAIL wr_hwdata c%0d: got %h want %h", k, HWDATA, ed[k]); end
            tests++;
            if (busy !== eb[k] || done !== edn[k]) begin
                failed++; $display("FAIL wr_busy_done c%0d: got %b%b want %b%b", k, busy, done, eb[k], edn[k]);
            end
            if (k <= 4) begin
                tests++;
                if (HWRITE !== 1'b1 || HSIZE !== 3'b010 || HBURST !== HB_EXP) begin
                    failed++; $display("FAIL wr_ctrl c%0d: got wr=%b size=%h burst=%h want 1/2/%h", k, HWRITE, HSIZE, HBURST, HB_EXP);
                end
            end
            tick();
        end
    endtask

    task automatic test_read_wait();
        logic        rdy [1:9];
        logic [31:0] rdt [1:9];
        logic [1:0]  et  [1:9];
        logic [31:0] ea  [1:9];
        logic        eb  [1:9];
        logic        edn [1:9];
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rdt = '{32'h0, 32'hA0000000, 32'hB1111111, 32'hDEADBEEF, 32'hDEADBEEF, 32'hC2222222, 32'hD3333333, 32'h0, 32'h0};
        et  = '{2'b10, TB_EXP, TB_EXP, TB_EXP, TB_EXP, TB_EXP, 2'b00, 2'b00, 2'b00};
        ea  = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h1C, 32'h1C, 32'h0, 32'h0, 32'h0};
        eb  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        edn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        HRESP = 2'b00; HREADY = 1'b1;
        start_rd = 1'b1;
        tick();
        start_rd = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            HREADY = rdy[k];
            HRDATA = rdt[k];
            start_wr = (k == 3);  // must be ignored while busy
            tests++;
            if (HTRANS !== et[k] || HADDR !== ea[k]) begin
                failed++; $display("FAIL rd_addr c%0d: got %h/%h want %h/%h", k, HTRANS, HADDR, et[k], ea[k]);
            end
            tests++;
            if (busy !== eb[k] || done !== edn[k] || HWRITE !== 1'b0) begin
                failed++; $display("FAIL rd_status c%0d: got busy=%b done=%b wr=%b want %b/%b/0", k, busy, done, HWRITE, eb[k], edn[k]);
            end
            if (k == 8) begin
                tests++;
                if (rd_block !== RD_EXP) begin failed++; $display("FAIL rd_block: got %h want %h", rd_block, RD_EXP); end
            end
            tick();
        end
        start_wr = 1'b0;
        HRDATA = '0;
        tests++;
        if (HTRANS !== 2'b00 || busy !== 1'b0) begin
            failed++; $display("FAIL rd_ignored_start: got trans=%h busy=%b want 0/0", HTRANS, busy);
        end
    endtask

    task automatic test_both_starts();
        int active = 0;
        HREADY = 1'b1; HRESP = 2'b00;
        wr_block = 128'h11111111_22222222_33333333_44444444;
        start_wr = 1'b1; start_rd = 1'b1;
        tick();
        start_wr = 1'b0; start_rd = 1'b0;
        tests++;
        if (HTRANS !== 2'b10 || HWRITE !== 1'b1) begin
            failed++; $display("FAIL both_first: got trans=%h wr=%b want 2/1", HTRANS, HWRITE);
        end
        tick();
        tests++;
        if (HWDATA !== 32'h11111111) begin failed++; $display("FAIL both_wdata0: got %h want 11111111", HWDATA); end
        tick(); tick(); tick(); tick();
        tests++;
        if (done !== 1'b1) begin failed++; $display("FAIL both_done_c6: got %b want 1", done); end
        for (int k = 7; k <= 16; k++) begin
            tick();
            if (HTRANS !== 2'b00 || busy !== 1'b0) active++;
        end
        tests++;
        if (active !== 0) begin failed++; $display("FAIL both_no_read: got %0d active cycles want 0", active); end
        tests++;
        if (rd_block !== RD_EXP) begin failed++; $display("FAIL both_rd_block: got %h want %h", rd_block, RD_EXP); end
    endtask

    task automatic test_error();
        int n_done = 0;
        int n_err = 0;
        HREADY = 1'b1; HRESP = 2'b00;
        start_rd = 1'b1;
        tick();
        start_rd = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            HREADY = (k != 3);
            HRESP  = (k == 3 || k == 4) ? 2'b01 : 2'b00;
            HRDATA = (k == 2) ? 32'h11111111 : 32'h0;
            if (done) n_done++;
            if (error) n_err++;
            if (k == 4) begin
                tests++;
                if (HTRANS !== 2'b00 || error !== 1'b1 || busy !== 1'b0) begin
                    failed++; $display("FAIL err_abort c4: got trans=%h err=%b busy=%b want 0/1/0", HTRANS, error, busy);
                end
            end
            tick();
        end
        HRESP = 2'b00;
        tests++;
        if (n_done !== 0 || n_err !== 1) begin
            failed++; $display("FAIL err_pulses: got done=%0d err=%0d want 0/1", n_done, n_err);
        end
        tests++;
        if (rd_block !== RD_EXP) begin failed++; $display("FAIL err_rd_block: got %h want %h", rd_block, RD_EXP); end
    endtask

    task automatic test_reset_mid_burst();
        HREADY = 1'b1; HRESP = 2'b00;
        wr_block = 128'hCAFE0000_CAFE1111_CAFE2222_CAFE3333;
        start_wr = 1'b1;
        tick();
        start_wr = 1'b0;
        tick(); tick(); tick();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        tests++;
        if ({HTRANS, HADDR, HWRITE, HWDATA, HSIZE, HBURST, busy, done, error} !== '0 || rd_block !== '0) begin
            failed++;
            $display("FAIL rst_mid: got trans=%h addr=%h wr=%b wdata=%h busy=%b done=%b err=%b rd=%h want all 0",
                     HTRANS, HADDR, HWRITE, HWDATA, busy, done, error, rd_block);
        end
        wr_block = 128'h0BAD0000_0BAD1111_0BAD2222_0BAD3333;
        start_wr = 1'b1;
        tick();
        start_wr = 1'b0;
        tests++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h10) begin
            failed++; $display("FAIL rst_restart_c1: got %h/%h want 2/00000010", HTRANS, HADDR);
        end
        tick(); tick(); tick(); tick();
        tests++;
        if (HWDATA !== 32'h0BAD3333 || HTRANS !== 2'b00) begin
            failed++; $display("FAIL rst_restart_c5: got %h/%h want 0bad3333/0", HWDATA, HTRANS);
        end
        tick();
        tests++;
        if (done !== 1'b1) begin failed++; $display("FAIL rst_restart_done: got %b want 1", done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_read_wait();
        test_both_starts();
        test_error();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
